// File: rtl/alu_result_buffer_pkg.sv
// Shared types for the ALU result buffer: status flags, buffer occupancy states
// and the mapping from state to occupied-entry count.
package alu_result_buffer_pkg;

    typedef struct packed {
        logic overflow;
        logic negative;
        logic zero;
        logic equal;
        logic greater;
        logic less;
    } alu_flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    function automatic logic [1:0] state_count(buf_state_t s);
        logic [1:0] c;
        c = 2'd0;
        case (s)
            ONE:     c = 2'd1;
            FULL:    c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_result_buffer.sv
// Two-entry in-order skid buffer between the ALU and memory stages.
// Optional operand-bypass outputs are enabled with the ALU_BUF_FWD_EN macro.
//
// state | meaning
// EMPTY | no entry buffered, out_valid low
// ONE   | head entry in main, skid unused
// FULL  | head in main, younger entry in skid, upstream stalled
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_result,
    input  alu_flags_t      in_flags,
    input  logic [4:0]      in_rd,
    input  logic            in_wb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_result,
    output alu_flags_t      out_flags,
    output logic [4:0]      out_rd,
    output logic            out_wb,
`ifdef ALU_BUF_FWD_EN
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [SIZE-1:0] fwd_result,
`endif
    input  logic            flush,
    output logic [1:0]      count
);

    typedef struct packed {
        logic [SIZE-1:0] result;
        alu_flags_t      flags;
        logic [4:0]      rd;
        logic            wb;
    } buf_entry_t;

    buf_state_t state_q, state_d;
    buf_entry_t main_q, main_d;
    buf_entry_t skid_q, skid_d;
    buf_entry_t in_entry;
    logic       accept;
    logic       pop;

    assign in_entry = '{result: in_result, flags: in_flags, rd: in_rd, wb: in_wb};

    // in_ready comes from the state register only, so there is no out_ready -> in_ready path
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign count     = state_count(state_q);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state_d = FULL;
                        skid_d  = in_entry;
                    end else if (pop && !accept) begin
                        state_d = EMPTY;
                    end else if (accept && pop) begin
                        main_d  = in_entry;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_result = main_q.result;
    assign out_flags  = main_q.flags;
    assign out_rd     = main_q.rd;
    assign out_wb     = main_q.wb;

`ifdef ALU_BUF_FWD_EN
    buf_entry_t youngest;

    // Bypass must see the most recent producer, which sits in skid when both entries are live
    assign youngest   = (state_q == FULL) ? skid_q : main_q;
    assign fwd_valid  = out_valid & youngest.wb & (youngest.rd != 5'd0);
    assign fwd_rd     = youngest.rd;
    assign fwd_result = youngest.result;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus a random
// run against a queue model of the buffered entries.
module tb_alu_result_buffer;
    import alu_result_buffer_pkg::*;

    localparam int SIZE = 64;

    typedef struct packed {
        logic [SIZE-1:0] result;
        alu_flags_t      flags;
        logic [4:0]      rd;
        logic            wb;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SIZE-1:0] in_result = '0;
    alu_flags_t      in_flags = '0;
    logic [4:0]      in_rd = '0;
    logic            in_wb = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SIZE-1:0] out_result;
    alu_flags_t      out_flags;
    logic [4:0]      out_rd;
    logic            out_wb;
    logic            flush = 1'b0;
    logic [1:0]      count;
`ifdef ALU_BUF_FWD_EN
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [SIZE-1:0] fwd_result;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t emitted[$];
    exp_t hold = '0;

    alu_result_buffer #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd), .in_wb(in_wb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_rd(out_rd), .out_wb(out_wb),
`ifdef ALU_BUF_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result),
`endif
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    function automatic exp_t cur_in();
        return '{result: in_result, flags: in_flags, rd: in_rd, wb: in_wb};
    endfunction

    function automatic exp_t obs();
        return '{result: out_result, flags: out_flags, rd: out_rd, wb: out_wb};
    endfunction

    function automatic exp_t head_exp();
        return (q.size() > 0) ? q[0] : hold;
    endfunction

    task automatic drive(input logic v, input logic [SIZE-1:0] r, input logic [5:0] f,
                         input logic [4:0] rd, input logic wb);
        in_valid  = v;
        in_result = r;
        in_flags  = f;
        in_rd     = rd;
        in_wb     = wb;
    endtask

    // Advance one clock and update the reference model with the inputs seen at the edge.
    task automatic tick();
        bit do_pop, do_acc;
        @(posedge clk);
        do_pop = (q.size() > 0) && out_ready;
        do_acc = in_valid && (q.size() < 2);
        if (reset) begin
            q.delete();
            hold = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (do_pop) begin
                emitted.push_back(q[0]);
                void'(q.pop_front());
            end
            if (do_acc) q.push_back(cur_in());
        end
        if (!reset && q.size() > 0) hold = q[0];
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 64'hDEAD, 6'h3F, 5'd9, 1'b1);
        out_ready = 1'b1;
        flush = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got out_valid=%b count=%0d in_ready=%b, want 0 0 1", out_valid, count, in_ready);
        end
        checks++;
        if (obs() !== exp_t'('0)) begin
            errors++;
            $display("FAIL reset_payload: got %h, want 0", obs());
        end
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || $isunknown(obs())) begin
            errors++;
            $display("FAIL reset_idle: got out_valid=%b payload=%h, want 0 and known", out_valid, obs());
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 64'h5, 6'h0, 5'd3, 1'b1);
        out_ready = 1'b1;
        tick();
        drive(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 64'h5 || out_rd !== 5'd3 || count !== 2'd1) begin
            errors++;
            $display("FAIL basic_latency: got v=%b res=%h rd=%0d count=%0d, want 1 5 3 1", out_valid, out_result, out_rd, count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 || out_result !== 64'h5) begin
            errors++;
            $display("FAIL basic_drain_hold: got v=%b count=%0d res=%h, want 0 0 5", out_valid, count, out_result);
        end
    endtask

    task automatic test_backpressure();
        int budget;
        emitted.delete();
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 6'h01, 5'd1, 1'b1);
        tick();
        drive(1'b1, 64'hB, 6'h02, 5'd2, 1'b1);
        tick();
        checks++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: got count=%0d in_ready=%b, want 2 0", count, in_ready);
        end
        drive(1'b1, 64'hC, 6'h04, 5'd4, 1'b1);
        tick();
        checks++;
        if (count !== 2'd2 || out_result !== 64'hA) begin
            errors++;
            $display("FAIL bp_hold: got count=%0d head=%h, want 2 a", count, out_result);
        end
        out_ready = 1'b1;
        budget = 0;
        while ((emitted.size() < 3 || q.size() > 0) && budget < 20) begin
            if (q.size() > 0 && q[$].result == 64'hC) drive(1'b0, '0, '0, '0, 1'b0);
            tick();
            budget++;
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (budget >= 20) begin
            errors++;
            $display("FAIL bp_timeout: drained %0d entries, want 3", emitted.size());
        end
        checks++;
        if (emitted.size() != 3) begin
            errors++;
            $display("FAIL bp_order_count: got %0d entries, want 3", emitted.size());
        end else if (emitted[0].result !== 64'hA || emitted[1].result !== 64'hB || emitted[2].result !== 64'hC) begin
            errors++;
            $display("FAIL bp_order: got %h %h %h, want a b c", emitted[0].result, emitted[1].result, emitted[2].result);
        end
        checks++;
        if (out_valid !== 1'b0 || out_result !== 64'hC) begin
            errors++;
            $display("FAIL bp_empty: got v=%b res=%h, want 0 c", out_valid, out_result);
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        drive(1'b1, 64'hD, 6'h08, 5'd5, 1'b0);
        tick();
        drive(1'b1, 64'hE, 6'h10, 5'd6, 1'b1);
        tick();
        drive(1'b1, 64'hF, 6'h20, 5'd7, 1'b1);
        out_ready = 1'b1;
        tick();
        drive(1'b0, '0, '0, '0, 1'b0);
        out_ready = 1'b0;
        checks++;
        if (count !== 2'd1 || out_result !== 64'hE || out_rd !== 5'd6 || out_flags !== 6'h10 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: got count=%0d res=%h rd=%0d flags=%h in_ready=%b, want 1 e 6 10 1",
                     count, out_result, out_rd, out_flags, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_drop: got count=%0d v=%b, want 0 0 (F must not be accepted)", count, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 6'h01, 5'd8, 1'b1);
        tick();
        drive(1'b1, 64'h22, 6'h02, 5'd9, 1'b1);
        tick();
        drive(1'b1, 64'h77, 6'h03, 5'd10, 1'b1);
        flush = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_inready: got %b, want 0 during flush cycle while FULL", in_ready);
        end
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: got count=%0d v=%b in_ready=%b, want 0 0 1", count, out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost: got out_valid=%b res=%h, want 0", out_valid, out_result);
            end
        end
        // flush while accepting into an empty buffer must discard the input too
        drive(1'b1, 64'h99, 6'h05, 5'd11, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_result === 64'h99) begin
            errors++;
            $display("FAIL flush_accept: got v=%b res=%h, want 0 and not 99", out_valid, out_result);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 64'h33, 6'h01, 5'd12, 1'b1);
        tick();
        drive(1'b1, 64'h44, 6'h02, 5'd13, 1'b1);
        tick();
        reset = 1'b1;
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || obs() !== exp_t'('0)) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d v=%b in_ready=%b payload=%h, want 0 0 1 0",
                     count, out_valid, in_ready, obs());
        end
    endtask

`ifdef ALU_BUF_FWD_EN
    task automatic test_fwd();
        out_ready = 1'b0;
        drive(1'b1, 64'h55, 6'h00, 5'd0, 1'b1);
        tick();
        checks++;
        if (fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_rd0: got fwd_valid=%b, want 0", fwd_valid);
        end
        drive(1'b1, 64'h1234, 6'h00, 5'd7, 1'b1);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_result !== 64'h1234) begin
            errors++;
            $display("FAIL fwd_young: got v=%b rd=%0d res=%h, want 1 7 1234", fwd_valid, fwd_rd, fwd_result);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_empty: got fwd_valid=%b, want 0", fwd_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic ir_a;
        exp_t e;
        for (int cyc = 0; cyc < 10000 && errors < 20; cyc++) begin
            drive($urandom_range(0, 1) == 1, {$urandom, $urandom}, 6'($urandom), 5'($urandom), 1'($urandom));
            flush = ($urandom_range(0, 49) == 0);
            out_ready = 1'b1;
            #1;
            ir_a = in_ready;
            out_ready = 1'b0;
            #1;
            checks++;
            if (in_ready !== ir_a) begin
                errors++;
                $display("FAIL rnd_ready_path cyc %0d: in_ready %b with out_ready=0, %b with out_ready=1", cyc, in_ready, ir_a);
            end
            out_ready = $urandom_range(0, 1) == 1;
            #1;
            e = head_exp();
            checks++;
            if (count !== 2'(q.size()) || in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
                errors++;
                $display("FAIL rnd_ctrl cyc %0d: got count=%0d in_ready=%b v=%b, want count=%0d", cyc, count, in_ready, out_valid, q.size());
            end
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL rnd_payload cyc %0d: got %h, want %h", cyc, obs(), e);
            end
`ifdef ALU_BUF_FWD_EN
            checks++;
            if (q.size() > 0) begin
                if (fwd_valid !== (q[$].wb && q[$].rd != 0) || fwd_rd !== q[$].rd || fwd_result !== q[$].result) begin
                    errors++;
                    $display("FAIL rnd_fwd cyc %0d: got v=%b rd=%0d res=%h, want rd=%0d res=%h",
                             cyc, fwd_valid, fwd_rd, fwd_result, q[$].rd, q[$].result);
                end
            end else if (fwd_valid !== 1'b0) begin
                errors++;
                $display("FAIL rnd_fwd cyc %0d: got fwd_valid=%b while empty, want 0", cyc, fwd_valid);
            end
`endif
            tick();
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        flush = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full_pop();
        test_flush();
        test_reset_mid();
`ifdef ALU_BUF_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter SIZE, default 64, datapath width matching the ALU result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: the upstream handshake from the ALU stage.
REQ-005 SHALL have ports in_result input SIZE, in_flags input alu_flags_t (6 bits), in_rd input 5 and in_wb input 1: the ALU result, status flags, destination register and writeback enable.
REQ-006 SHALL have ports out_valid output 1 and out_ready input 1: the downstream handshake to the memory stage.
REQ-007 SHALL have ports out_result output SIZE, out_flags output alu_flags_t, out_rd output 5 and out_wb output 1: the head-entry payload.
REQ-008 SHALL have port flush  input  1  discards all buffered entries.
REQ-009 SHALL have port count  output 2  number of occupied entries (0..2).

Function
REQ-010 SHALL implement a 2-entry in-order skid buffer, with entries main (head, drives out_*) and skid.
REQ-011 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-012 SHALL use a state machine EMPTY/ONE/FULL, with count = 0/1/2 and out_valid = (state != EMPTY).
REQ-013 SHALL derive in_ready = (state != FULL) from registered state only, with no combinational path from out_ready.
REQ-014 Transitions from EMPTY: accept -> ONE (payload into main); otherwise stay.
REQ-015 Transitions from ONE: accept & !pop -> FULL (payload into skid); pop & !accept -> EMPTY; accept & pop -> ONE (new payload into main); neither -> stay.
REQ-016 Transitions from FULL: pop -> ONE (skid moves into main in the same edge); no accept possible.
REQ-017 SHALL emit entries exactly once each, in acceptance order; each entry's payload (result, flags, rd, wb) SHALL stay bit-identical while buffered.
REQ-018 Latency SHALL be 1 cycle: a payload accepted at edge N is visible on out_* after edge N if main was empty or popped at N.
REQ-019 Payload registers SHALL load only on accept or skid->main shift; out_* SHALL hold the last value when out_valid=0.
REQ-020 flush SHALL take priority over accept and pop: next state is EMPTY, and any same-cycle accept is discarded; in_ready is unaffected by flush in the current cycle.
REQ-021 out_* SHALL never be X after reset, for any input sequence.

Reset
REQ-022 With reset asserted at an edge: state -> EMPTY, out_valid=0, count=0, out_result=0, out_flags=0, out_rd=0, out_wb=0, skid payload=0; in_ready=1 after that edge.
REQ-023 Reset mid-operation SHALL drop all buffered entries, and SHALL take priority over flush, accept and pop.

Configuration
REQ-024 Macro ALU_BUF_FWD_EN defined: SHALL add outputs fwd_valid (1), fwd_rd (5) and fwd_result (SIZE), driven combinationally from the youngest buffered entry (skid if FULL, else main). fwd_valid = out_valid & youngest.wb & (youngest.rd != 0); these outputs are for operand bypass.
REQ-025 Macro ALU_BUF_FWD_EN undefined: the fwd_* ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Packed struct alu_flags_t {overflow, negative, zero, equal, greater, less} and enum buf_state_t {EMPTY, ONE, FULL} SHALL live in the shared operations package.
REQ-027 Payload SHALL be a packed struct buf_entry_t {result, flags, rd, wb} declared locally.
REQ-028 The block SHALL be a single module with no sub-module; the ALU instance stays outside it.

Verification
REQ-029 Reset, then in_valid=1, in_result=0x5, rd=3, wb=1, out_ready=1 -> next cycle out_valid=1, out_result=0x5, out_rd=3, count=1.
REQ-030 out_ready=0 while pushing 0xA then 0xB -> count=2, in_ready=0; third value 0xC held upstream; out_ready=1 -> out 0xA, 0xB, 0xC in order, no loss or duplication.
REQ-031 FULL with out_ready=1 and in_valid=1 in the same cycle -> pop only, state ONE, out_result=skid value, new input not accepted.
REQ-032 FULL state plus flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, flushed-cycle input never emitted.
REQ-033 Random in_valid/out_ready (10k cycles, SIZE=64) -> scoreboard matches in-order payloads; in_ready never depends on same-cycle out_ready.
REQ-034 ALU_BUF_FWD_EN defined: push rd=0 wb=1 -> fwd_valid=0; then rd=7 wb=1 result=0x1234 with out_ready=0 -> fwd_valid=1, fwd_rd=7, fwd_result=0x1234.
